// File: rtl/commit_unit.sv
// In-order retirement stage: drains one ROB commit per cycle into regfile/LSB writes,
// raises a global flush plus fetch redirect on mispredict, latches halt, counts retirements.
module commit_unit #(
    parameter int unsigned ID_W         = 6,
    parameter int unsigned REG_W        = 5,
    parameter int unsigned ROB_W        = 4,
    parameter int unsigned LSB_W        = 4,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STORE_ID_LO  = 20,
    parameter int unsigned STORE_ID_HI  = 22,
    parameter int unsigned BRANCH_ID_LO = 10,
    parameter int unsigned BRANCH_ID_HI = 15,
    parameter int unsigned HALT_ID      = 63,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             commit_en_in,
    input  logic [ID_W-1:0]  instr_id_in,
    input  logic [REG_W-1:0] rd_in,
    input  logic [ROB_W-1:0] rob_pos_in,
    input  logic [LSB_W-1:0] lsb_pos_in,
    input  logic [XLEN-1:0]  res_in,
    input  logic             jump_en_in,
    input  logic [XLEN-1:0]  jump_a_in,
    output logic             rf_we_out,
    output logic [REG_W-1:0] rf_rd_out,
    output logic [XLEN-1:0]  rf_data_out,
    output logic [ROB_W-1:0] rf_rob_tag_out,
    output logic             lsb_commit_en_out,
    output logic [LSB_W-1:0] lsb_commit_pos_out,
    output logic             clear_branch_out,
    output logic             pc_redirect_en_out,
    output logic [XLEN-1:0]  pc_redirect_a_out,
    output logic             halt_out,
    output logic [31:0]      commit_cnt_out
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, HALT} state_t;

    state_t          state;
    logic [FC_W-1:0] flush_cnt;

    logic is_store;
    logic is_branch;
    logic is_halt;

    assign is_store  = (instr_id_in >= ID_W'(STORE_ID_LO))  && (instr_id_in <= ID_W'(STORE_ID_HI));
    assign is_branch = (instr_id_in >= ID_W'(BRANCH_ID_LO)) && (instr_id_in <= ID_W'(BRANCH_ID_HI));
    assign is_halt   = (instr_id_in == ID_W'(HALT_ID));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= IDLE;
            flush_cnt          <= '0;
            rf_we_out          <= 1'b0;
            rf_rd_out          <= '0;
            rf_data_out        <= '0;
            rf_rob_tag_out     <= '0;
            lsb_commit_en_out  <= 1'b0;
            lsb_commit_pos_out <= '0;
            clear_branch_out   <= 1'b0;
            pc_redirect_en_out <= 1'b0;
            pc_redirect_a_out  <= '0;
            halt_out           <= 1'b0;
            commit_cnt_out     <= '0;
        end else if (rdy_in) begin
            // single-cycle strobes
            rf_we_out          <= 1'b0;
            lsb_commit_en_out  <= 1'b0;
            pc_redirect_en_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit_en_in) begin
                        commit_cnt_out <= commit_cnt_out + 32'd1;
                        if (is_halt) begin
                            state    <= HALT;
                            halt_out <= 1'b1;
                        end else begin
                            if (is_store) begin
                                lsb_commit_en_out  <= 1'b1;
                                lsb_commit_pos_out <= lsb_pos_in;
                            end else if (!is_branch && (rd_in != '0)) begin
                                rf_we_out      <= 1'b1;
                                rf_rd_out      <= rd_in;
                                rf_data_out    <= res_in;
                                rf_rob_tag_out <= rob_pos_in;
                            end
                            // link write above still goes out alongside the redirect
                            if (jump_en_in) begin
                                pc_redirect_en_out <= 1'b1;
                                pc_redirect_a_out  <= jump_a_in;
                                clear_branch_out   <= 1'b1;
                                flush_cnt          <= FC_W'(FLUSH_CYCLES - 1);
                                state              <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        clear_branch_out <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                HALT: begin
                    halt_out <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: instance a uses FLUSH_CYCLES=1, instance b FLUSH_CYCLES=3.
module tb_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        commit_en;
    logic [5:0]  instr_id;
    logic [4:0]  rd;
    logic [3:0]  rob_pos;
    logic [3:0]  lsb_pos;
    logic [31:0] res;
    logic        jump_en;
    logic [31:0] jump_a;

    logic        we_a, lsb_en_a, clr_a, redir_a, halt_a;
    logic [4:0]  rrd_a;
    logic [31:0] data_a, pca_a, cnt_a;
    logic [3:0]  tag_a, lpos_a;

    logic        we_b, lsb_en_b, clr_b, redir_b, halt_b;
    logic [4:0]  rrd_b;
    logic [31:0] data_b, pca_b, cnt_b;
    logic [3:0]  tag_b, lpos_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    commit_unit dut_a (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .commit_en_in(commit_en),
        .instr_id_in(instr_id), .rd_in(rd), .rob_pos_in(rob_pos), .lsb_pos_in(lsb_pos),
        .res_in(res), .jump_en_in(jump_en), .jump_a_in(jump_a),
        .rf_we_out(we_a), .rf_rd_out(rrd_a), .rf_data_out(data_a), .rf_rob_tag_out(tag_a),
        .lsb_commit_en_out(lsb_en_a), .lsb_commit_pos_out(lpos_a), .clear_branch_out(clr_a),
        .pc_redirect_en_out(redir_a), .pc_redirect_a_out(pca_a), .halt_out(halt_a),
        .commit_cnt_out(cnt_a)
    );

    commit_unit #(.FLUSH_CYCLES(3)) dut_b (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .commit_en_in(commit_en),
        .instr_id_in(instr_id), .rd_in(rd), .rob_pos_in(rob_pos), .lsb_pos_in(lsb_pos),
        .res_in(res), .jump_en_in(jump_en), .jump_a_in(jump_a),
        .rf_we_out(we_b), .rf_rd_out(rrd_b), .rf_data_out(data_b), .rf_rob_tag_out(tag_b),
        .lsb_commit_en_out(lsb_en_b), .lsb_commit_pos_out(lpos_b), .clear_branch_out(clr_b),
        .pc_redirect_en_out(redir_b), .pc_redirect_a_out(pca_b), .halt_out(halt_b),
        .commit_cnt_out(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        commit_en = 1'b0; instr_id = '0; rd = '0; rob_pos = '0; lsb_pos = '0;
        res = '0; jump_en = 1'b0; jump_a = '0;
    endtask

    task automatic put(input logic [5:0] id, input logic [4:0] r, input logic [3:0] rob,
                       input logic [3:0] lp, input logic [31:0] v, input logic j,
                       input logic [31:0] ja);
        commit_en = 1'b1; instr_id = id; rd = r; rob_pos = rob; lsb_pos = lp;
        res = v; jump_en = j; jump_a = ja;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_we"}, 32'(we_a), 0);     chk({tag, "_rd"}, 32'(rrd_a), 0);
        chk({tag, "_data"}, data_a, 0);      chk({tag, "_tag"}, 32'(tag_a), 0);
        chk({tag, "_lsb"}, 32'(lsb_en_a), 0); chk({tag, "_lpos"}, 32'(lpos_a), 0);
        chk({tag, "_clr"}, 32'(clr_a), 0);   chk({tag, "_redir"}, 32'(redir_a), 0);
        chk({tag, "_pca"}, pca_a, 0);        chk({tag, "_halt"}, 32'(halt_a), 0);
        chk({tag, "_cnt"}, cnt_a, 0);
    endtask

    task automatic chk_zero_b(input string tag);
        chk({tag, "_we"}, 32'(we_b), 0);     chk({tag, "_rd"}, 32'(rrd_b), 0);
        chk({tag, "_data"}, data_b, 0);      chk({tag, "_tag"}, 32'(tag_b), 0);
        chk({tag, "_lsb"}, 32'(lsb_en_b), 0); chk({tag, "_lpos"}, 32'(lpos_b), 0);
        chk({tag, "_clr"}, 32'(clr_b), 0);   chk({tag, "_redir"}, 32'(redir_b), 0);
        chk({tag, "_pca"}, pca_b, 0);        chk({tag, "_halt"}, 32'(halt_b), 0);
        chk({tag, "_cnt"}, cnt_b, 0);
    endtask

    initial begin
        idle_in();
        rst = 1'b1; rdy = 1'b1;
        cyc(); cyc();
        chk_zero_a("rst_a");
        chk_zero_b("rst_b");
        rst = 1'b0;

        // 1: plain ALU commit
        put(6'd0, 5'd5, 4'd3, 4'd0, 32'hDEADBEEF, 1'b0, 32'h0);
        cyc(); idle_in();
        chk("alu_we", 32'(we_a), 1);    chk("alu_rd", 32'(rrd_a), 5);
        chk("alu_data", data_a, 32'hDEADBEEF);
        chk("alu_tag", 32'(tag_a), 3);  chk("alu_cnt", cnt_a, 1);
        chk("alu_lsb", 32'(lsb_en_a), 0); chk("alu_redir", 32'(redir_a), 0);
        cyc();
        chk("alu_we_pulse", 32'(we_a), 0); chk("alu_cnt_hold", cnt_a, 1);

        // 2: rd=0, store, branch
        put(6'd0, 5'd0, 4'd1, 4'd0, 32'h1234, 1'b0, 32'h0);
        cyc();
        chk("x0_we", 32'(we_a), 0);     chk("x0_cnt", cnt_a, 2);
        put(6'd21, 5'd9, 4'd2, 4'd7, 32'h55, 1'b0, 32'h0);
        cyc();
        chk("st_lsb", 32'(lsb_en_a), 1); chk("st_pos", 32'(lpos_a), 7);
        chk("st_we", 32'(we_a), 0);      chk("st_cnt", cnt_a, 3);
        put(6'd12, 5'd4, 4'd4, 4'd0, 32'h1, 1'b0, 32'h0);
        cyc();
        chk("br_we", 32'(we_a), 0);      chk("br_lsb", 32'(lsb_en_a), 0);
        chk("br_cnt", cnt_a, 4);

        // 3: JALR with redirect, dropped commit during flush, then accepted commit
        put(6'd30, 5'd1, 4'd5, 4'd0, 32'h104, 1'b1, 32'h200);
        cyc();
        chk("jalr_we", 32'(we_a), 1);    chk("jalr_rd", 32'(rrd_a), 1);
        chk("jalr_data", data_a, 32'h104);
        chk("jalr_redir", 32'(redir_a), 1); chk("jalr_pca", pca_a, 32'h200);
        chk("jalr_clr", 32'(clr_a), 1);  chk("jalr_cnt", cnt_a, 5);
        put(6'd0, 5'd6, 4'd6, 4'd0, 32'h66, 1'b0, 32'h0);
        cyc();
        chk("fl_clr", 32'(clr_a), 0);    chk("fl_redir", 32'(redir_a), 0);
        chk("fl_we", 32'(we_a), 0);      chk("fl_cnt", cnt_a, 5);
        put(6'd0, 5'd7, 4'd7, 4'd0, 32'h77, 1'b0, 32'h0);
        cyc(); idle_in();
        chk("b2b_we", 32'(we_a), 1);     chk("b2b_rd", 32'(rrd_a), 7);
        chk("b2b_data", data_a, 32'h77); chk("b2b_cnt", cnt_a, 6);

        // 4: three-cycle flush on instance b
        rst = 1'b1; cyc(); rst = 1'b0;
        put(6'd12, 5'd3, 4'd1, 4'd0, 32'h0, 1'b1, 32'h300);
        cyc(); idle_in();
        chk("f3_clr1", 32'(clr_b), 1);   chk("f3_redir1", 32'(redir_b), 1);
        chk("f3_pca", pca_b, 32'h300);   chk("f3_we", 32'(we_b), 0);
        chk("f3_cnt", cnt_b, 1);         chk("f1_clr1", 32'(clr_a), 1);
        cyc();
        chk("f3_clr2", 32'(clr_b), 1);   chk("f3_redir2", 32'(redir_b), 0);
        chk("f1_clr2", 32'(clr_a), 0);
        cyc();
        chk("f3_clr3", 32'(clr_b), 1);
        cyc();
        chk("f3_clr4", 32'(clr_b), 0);

        // 5: rdy_in low freezes everything
        put(6'd0, 5'd3, 4'd2, 4'd0, 32'h33, 1'b0, 32'h0);
        cyc();
        chk("pre_we", 32'(we_a), 1);     chk("pre_cnt", cnt_a, 2);
        rdy = 1'b0;
        put(6'd0, 5'd8, 4'd9, 4'd0, 32'h88, 1'b1, 32'h400);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("frz_we", 32'(we_a), 1);   chk("frz_rd", 32'(rrd_a), 3);
            chk("frz_cnt", cnt_a, 2);      chk("frz_clr", 32'(clr_a), 0);
            chk("frz_redir", 32'(redir_a), 0);
        end
        rdy = 1'b1; idle_in();
        cyc();
        chk("thaw_we", 32'(we_a), 0);    chk("thaw_cnt", cnt_a, 2);

        // reset in the middle of a flush
        put(6'd13, 5'd0, 4'd0, 4'd0, 32'h0, 1'b1, 32'h500);
        cyc(); idle_in();
        chk("mf_clr", 32'(clr_b), 1);
        rst = 1'b1;
        cyc();
        chk_zero_b("mfrst_b");
        rst = 1'b0;
        cyc();
        chk("mf_after_clr", 32'(clr_b), 0);

        // 6: halt wins over jump and is sticky
        put(6'd63, 5'd5, 4'd1, 4'd0, 32'h9, 1'b1, 32'h600);
        cyc();
        chk("h_halt", 32'(halt_a), 1);   chk("h_redir", 32'(redir_a), 0);
        chk("h_clr", 32'(clr_a), 0);     chk("h_we", 32'(we_a), 0);
        chk("h_cnt", cnt_a, 1);
        put(6'd0, 5'd5, 4'd1, 4'd0, 32'hAA, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hs_halt", 32'(halt_a), 1); chk("hs_we", 32'(we_a), 0);
            chk("hs_cnt", cnt_a, 1);
        end
        idle_in();
        rst = 1'b1;
        cyc();
        chk_zero_a("hrst_a");
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
